// File: rtl/acc_op_sequencer_pkg.sv
// Shared encodings for the accumulator op sequencer: command kinds, FSM states,
// accumulator input selects and datapath width defaults.
package acc_op_sequencer_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FNW_DEF   = 4;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_EXEC  = 2'b11
  } cmd_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SET   = 2'b01,
    ST_ISSUE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam logic SEL_INPUT = 1'b0;
  localparam logic SEL_CLEAR = 1'b1;

endpackage

// File: rtl/acc_op_sequencer_acc_reg.sv
// Accumulator register: loads either the input path or zero when enabled.
module acc_reg
  import acc_op_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= (sel == SEL_CLEAR) ? '0 : d;
    end
  end

endmodule

// File: rtl/acc_op_sequencer.sv
// One-command-at-a-time controller that sequences accumulator load/clear and
// ALU operations, returning the updated accumulator over a response handshake.
module acc_op_sequencer
  import acc_op_sequencer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int FNW     = FNW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [FNW-1:0]   cmd_fn,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FNW-1:0]   alu_fn,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_error,
  output logic             mux_sel,
  output logic [WIDTH-1:0] acc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e           state, state_nxt;
  cmd_kind_e        kind_q;
  logic [FNW-1:0]   fn_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    lat_cnt;
  logic             rsp_error_q;
  logic             acc_en;
  logic [WIDTH-1:0] acc_d;
  logic             accept;

  // Gating with rst_n keeps ready low while reset is held, even though IDLE is the reset state.
  assign cmd_ready = (state == ST_IDLE) && rst_n;
  assign accept    = cmd_valid && cmd_ready;
  assign alu_a     = acc;
  assign rsp_data  = acc;
  assign rsp_error = rsp_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_kind_e'(cmd_kind))
            CMD_NOP:             state_nxt = ST_RESP;
            CMD_LOAD, CMD_CLEAR: state_nxt = ST_SET;
            CMD_EXEC:            state_nxt = ST_ISSUE;
            default:             state_nxt = ST_RESP;
          endcase
        end
      end
      ST_SET:   state_nxt = ST_RESP;
      ST_ISSUE: if (lat_cnt == '0) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mux_sel   = SEL_INPUT;
    alu_b     = '0;
    alu_fn    = '0;
    rsp_valid = 1'b0;
    acc_en    = 1'b0;
    acc_d     = data_q;
    case (state)
      ST_SET: begin
        mux_sel = (kind_q == CMD_CLEAR) ? SEL_CLEAR : SEL_INPUT;
        acc_en  = 1'b1;
      end
      ST_ISSUE: begin
        alu_b  = data_q;
        alu_fn = fn_q;
        acc_d  = alu_result;
        acc_en = (lat_cnt == '0);
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q      <= CMD_NOP;
      fn_q        <= '0;
      data_q      <= '0;
      lat_cnt     <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (accept) begin
        kind_q  <= cmd_kind_e'(cmd_kind);
        fn_q    <= cmd_fn;
        data_q  <= cmd_data;
        lat_cnt <= CW'(ALU_LAT - 1);
      end else if (state == ST_ISSUE && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (state == ST_ISSUE && lat_cnt == '0) begin
        rsp_error_q <= alu_error;
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_error_q <= 1'b0;
      end
    end
  end

  acc_reg #(.WIDTH(WIDTH)) u_acc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc_en),
    .sel   (mux_sel),
    .d     (acc_d),
    .q     (acc)
  );

endmodule

// File: doc/acc_op_sequencer.md
Name: acc_op_sequencer

Overview:
Command-driven controller for the 16-bit ALU accumulator path. Accepts one command at a time over a valid/ready handshake. Sequences the input/clear select, the accumulator register update and an ALU operation. Returns the updated accumulator over a valid/ready response channel. Sits between the top-level test/driver logic and the combinational ALU.

Parameters:
WIDTH, 16, datapath/accumulator width
FNW, 4, ALU function-code width
ALU_LAT, 1, cycles the ALU operands/function are held before result capture (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_kind  in  2  00 NOP, 01 LOAD, 10 CLEAR, 11 EXEC
cmd_fn  in  FNW  ALU function code, used only for EXEC
cmd_data  in  WIDTH  LOAD value or EXEC operand B
alu_a  out  WIDTH  ALU operand A (always the accumulator)
alu_b  out  WIDTH  ALU operand B
alu_fn  out  FNW  ALU function code
alu_result  in  WIDTH  ALU result
alu_error  in  1  ALU error/overflow flag
mux_sel  out  1  accumulator input select: 0 input path, 1 clear (zero)
acc  out  WIDTH  current accumulator value
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  accumulator value after the command
rsp_error  out  1  alu_error captured for EXEC, else 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; acc, alu_b, alu_fn, rsp_data = 0; mux_sel, rsp_valid, rsp_error = 0; cmd_ready = 0 while rst_n low.
- Reset mid-command aborts the command: no response is issued and acc = 0.
- All outputs are registered or decoded from state plus registers only; there is no combinational path from cmd_* or rsp_ready to any output.
- States: IDLE, SET, ISSUE, RESP.
- IDLE: cmd_ready = 1. Command accepted on an edge with cmd_valid & cmd_ready. At accept, cmd_data, cmd_fn and cmd_kind are latched.
  - NOP goes to RESP.
  - LOAD and CLEAR go to SET.
  - EXEC goes to ISSUE with lat_cnt = ALU_LAT-1.
- SET (1 cycle): mux_sel = 1 for CLEAR, 0 for LOAD. At the next edge, acc <= (mux_sel ? 0 : latched data). Then go to RESP.
- ISSUE (ALU_LAT cycles):
  - alu_b = latched operand and alu_fn = latched fn, both held stable for the whole state.
  - lat_cnt decrements each edge.
  - At the edge where lat_cnt == 0: acc <= alu_result; rsp_error <= alu_error; go to RESP.
- RESP: rsp_valid = 1; rsp_data = acc; data held stable until rsp_ready. On the edge with rsp_valid & rsp_ready, go to IDLE and clear rsp_error.
- Outside ISSUE: alu_b = 0 and alu_fn = 0. alu_a = acc at all times. mux_sel = 0 outside SET.
- cmd_ready = 0 in SET/ISSUE/RESP. Exactly one command is in flight at a time, with no queuing.
- Latency from accept edge to rsp_valid high:
  - NOP: 1 cycle.
  - LOAD/CLEAR: 2 cycles.
  - EXEC: 1+ALU_LAT cycles.
- Response back-pressure: RESP holds indefinitely. The acc value is unchanged while waiting.
- Back-to-back operation: a new command can be accepted at the earliest the cycle after the response handshake, because IDLE must be re-entered first.
- Arithmetic: no arithmetic is done here. alu_result is taken unmodified at full WIDTH.
- The cmd_fn value is not checked; any code is forwarded as-is.

Decomposition:
- Shared package holds:
  - cmd_kind encodings (CMD_NOP, CMD_LOAD, CMD_CLEAR, CMD_EXEC).
  - State encodings.
  - SEL_INPUT = 0 and SEL_CLEAR = 1.
  - The WIDTH/FNW defaults.
- One natural sub-module: acc_reg. It is the WIDTH-bit accumulator register with async active-low reset, load enable and the input/clear select. The FSM drives its enable and select.

Test Plan:
- Reset then LOAD 16'h1234 -> acc = 16'h1234, rsp_valid 2 cycles after accept, rsp_data = 16'h1234, rsp_error = 0.
- LOAD 16'h00FF, then CLEAR -> mux_sel = 1 for exactly one cycle, acc = 16'h0000, rsp_data = 16'h0000.
- LOAD 16'h0005, EXEC fn=ADD B=16'h0003 with ALU model (ALU_LAT = 1, and rerun with ALU_LAT = 3) -> alu_a = 5, alu_b = 3 stable for ALU_LAT cycles, acc = 16'h0008, rsp_valid 1+ALU_LAT cycles after accept.
- EXEC with model forcing alu_error = 1 (16'h7FFF + 1) -> rsp_data = 16'h8000, rsp_error = 1; next NOP returns rsp_error = 0.
- Hold rsp_ready = 0 for 10 cycles while cmd_valid is held high with a new LOAD -> rsp_valid/rsp_data stable, cmd_ready = 0, second command accepted only after the handshake.
- Assert rst_n low during ISSUE -> immediate acc = 0, rsp_valid = 0, no response after release, cmd_ready = 1 in the first cycle after release.
